// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART core.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [WIDTH-1:0]             wr_data_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign wr_ready_o = (count_q != CW'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_ready_i && rd_valid_o;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with FIFO-buffered valid/ready streams, sticky RX error
// flags and an internal RX-to-TX echo path.
module uart_fifo_core import uart_pkg::*; #(
  parameter int CNT_WIDTH  = 24,
  parameter int CNT_INC    = 25770,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              uart_rx,
  output logic                              uart_tx,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  input  logic                              echo,
  input  logic                              err_clr,
  output logic                              rx_overrun,
  output logic                              rx_frame_err,
  output logic                              rx_parity_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_count
);
  localparam parity_e    PAR_MODE  = parity_e'(2'(PARITY));
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE-1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE-1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS-1);
  localparam logic       STOP_LAST = 1'(STOP_BITS-1);

  // Baud accumulator: carry-out is the 16x oversample tick.
  logic [CNT_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH:0]   acc_sum;
  logic                 tick;
  assign acc_sum = {1'b0, acc_q} + (CNT_WIDTH+1)'(CNT_INC);
  assign tick    = acc_sum[CNT_WIDTH];

  logic rx_meta_q, rx_s_q, rx_prev_q, rx_fall;
  assign rx_fall = rx_prev_q && !rx_s_q;

  logic [DATA_BITS-1:0] rxf_rd_data, txf_wr_data, txf_rd_data;
  logic rxf_wr_valid, rxf_wr_ready, rxf_rd_valid, rxf_rd_ready;
  logic txf_wr_valid, txf_wr_ready, txf_rd_valid, txf_pop;

  rx_state_e            rx_state_q, rx_state_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_done, rx_bit_end, par_bad;
  logic                 ovr_q, ferr_q, perr_q;
  logic                 ferr_set, perr_set, ovr_set;

  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_q, tx_d;
  logic                 tx_bit_end, tx_load;

  assign rx_bit_end = tick && (rx_cnt_q == LAST_TICK);
  assign tx_bit_end = tick && (tx_cnt_q == LAST_TICK);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    if (tick) rx_cnt_d = rx_cnt_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: if (tick && rx_cnt_q == MID_TICK) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == LAST_BIT)
          rx_state_d = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_par_d   = rx_s_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        rx_done    = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Disposition priority: framing, then parity, then overrun.
  assign par_bad      = (PAR_MODE != PAR_NONE) &&
                        (rx_par_q != ((^rx_shift_q) ^ (PAR_MODE == PAR_ODD)));
  assign ferr_set     = rx_done && !rx_s_q;
  assign perr_set     = rx_done && rx_s_q && par_bad;
  assign rxf_wr_valid = rx_done && rx_s_q && !par_bad;
  assign ovr_set      = rxf_wr_valid && !rxf_wr_ready;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    txf_pop    = 1'b0;
    if (tick) tx_cnt_d = tx_cnt_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_load  = tick && txf_rd_valid;
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit_q == LAST_BIT) begin
          if (PAR_MODE == PAR_NONE) begin
            tx_state_d = TX_STOP;
            tx_stop_d  = 1'b0;
            tx_d       = 1'b1;
          end else begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_stop_d  = 1'b0;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_stop_q == STOP_LAST) begin
          tx_state_d = TX_IDLE;
          tx_load    = txf_rd_valid;
        end else begin
          tx_stop_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading straight out of the last stop tick keeps frames gap-free.
    if (tx_load) begin
      txf_pop    = 1'b1;
      tx_state_d = TX_START;
      tx_shift_d = txf_rd_data;
      tx_par_d   = (^txf_rd_data) ^ (PAR_MODE == PAR_ODD);
      tx_cnt_d   = '0;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      acc_q      <= acc_sum[CNT_WIDTH-1:0];
      rx_meta_q  <= uart_rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      ovr_q      <= (ovr_q  && !err_clr) || ovr_set;
      ferr_q     <= (ferr_q && !err_clr) || ferr_set;
      perr_q     <= (perr_q && !err_clr) || perr_set;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
    end
  end

  // Echo steers the RX FIFO head into the TX FIFO and hides both host streams.
  assign rxf_rd_ready = echo ? txf_wr_ready : rx_ready;
  assign txf_wr_valid = echo ? rxf_rd_valid : tx_valid;
  assign txf_wr_data  = echo ? rxf_rd_data  : tx_data;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .wr_valid_i(rxf_wr_valid), .wr_ready_o(rxf_wr_ready), .wr_data_i(rx_shift_q),
    .rd_valid_o(rxf_rd_valid), .rd_ready_i(rxf_rd_ready), .rd_data_o(rxf_rd_data),
    .count_o(rx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .wr_valid_i(txf_wr_valid), .wr_ready_o(txf_wr_ready), .wr_data_i(txf_wr_data),
    .rd_valid_o(txf_rd_valid), .rd_ready_i(txf_pop), .rd_data_o(txf_rd_data),
    .count_o(tx_count)
  );

  assign uart_tx       = tx_q;
  assign rx_data       = rxf_rd_data;
  assign rx_valid      = rxf_rd_valid && !echo;
  assign tx_ready      = txf_wr_ready && !echo;
  assign rx_overrun    = ovr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: 8N1 loopback/echo/reset (a), 7E2 vector table (b), depth-4 overrun (c).
module tb_uart_fifo_core;
  localparam int BIT_A = 256;  // CNT_WIDTH 8, CNT_INC 16: 16 clk/tick
  localparam int BIT_B = 64;   // CNT_INC 64: 4 clk/tick
  localparam int BIT_C = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst = 1'b1;
  int total = 0, bad = 0;

  // instance a
  logic loop_a = 1'b0, drv_a = 1'b1, rx_a, tx_a;
  logic [7:0] tx_data_a = '0, rx_data_a;
  logic tx_valid_a = 0, tx_ready_a, rx_valid_a, rx_ready_a = 0, echo_a = 0, err_clr_a = 0;
  logic ovr_a, ferr_a, perr_a;
  logic [4:0] rx_count_a, tx_count_a;
  assign rx_a = loop_a ? tx_a : drv_a;

  // instance b
  logic drv_b = 1'b1, tx_b;
  logic [6:0] tx_data_b = '0, rx_data_b;
  logic tx_valid_b = 0, tx_ready_b, rx_valid_b, rx_ready_b = 0, echo_b = 0, err_clr_b = 0;
  logic ovr_b, ferr_b, perr_b;
  logic [4:0] rx_count_b, tx_count_b;

  // instance c
  logic drv_c = 1'b1, tx_c;
  logic [7:0] tx_data_c = '0, rx_data_c;
  logic tx_valid_c = 0, tx_ready_c, rx_valid_c, rx_ready_c = 0, echo_c = 0, err_clr_c = 0;
  logic ovr_c, ferr_c, perr_c;
  logic [2:0] rx_count_c, tx_count_c;

  uart_fifo_core #(.CNT_WIDTH(8), .CNT_INC(16), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .uart_rx(rx_a), .uart_tx(tx_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .echo(echo_a), .err_clr(err_clr_a), .rx_overrun(ovr_a), .rx_frame_err(ferr_a),
    .rx_parity_err(perr_a), .rx_count(rx_count_a), .tx_count(tx_count_a));

  uart_fifo_core #(.CNT_WIDTH(8), .CNT_INC(64), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .uart_rx(drv_b), .uart_tx(tx_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .echo(echo_b), .err_clr(err_clr_b), .rx_overrun(ovr_b), .rx_frame_err(ferr_b),
    .rx_parity_err(perr_b), .rx_count(rx_count_b), .tx_count(tx_count_b));

  uart_fifo_core #(.CNT_WIDTH(8), .CNT_INC(64), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .uart_rx(drv_c), .uart_tx(tx_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
    .echo(echo_c), .err_clr(err_clr_c), .rx_overrun(ovr_c), .rx_frame_err(ferr_c),
    .rx_parity_err(perr_c), .rx_count(rx_count_c), .tx_count(tx_count_c));

  typedef struct {
    logic [6:0] data;
    bit         bad_par;
    bit         bad_stop;
    bit         clr;
    int         exp_cnt;
    bit         exp_perr;
    bit         exp_ferr;
    logic [6:0] exp_data;
  } vec_t;
  vec_t vt[5];

  logic [8:0] echo_got[10];
  bit echo_done = 0;
  int echo_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: drv_a = v;
      1: drv_b = v;
      default: drv_c = v;
    endcase
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input int nbits, input int par,
                            input int nstop, input int bitc, input bit bad_par, input bit bad_stop);
    logic p;
    set_line(sel, 1'b0);
    repeat (bitc) @(negedge clk);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, d[i]);
      p = p ^ d[i];
      repeat (bitc) @(negedge clk);
    end
    if (par != 0) begin
      if (par == 2) p = ~p;
      if (bad_par) p = ~p;
      set_line(sel, p);
      repeat (bitc) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(sel, (s == 0 && bad_stop) ? 1'b0 : 1'b1);
      repeat (bitc) @(negedge clk);
    end
    set_line(sel, 1'b1);
  endtask

  // Returns {timeout, data}; t0 is the cycle at which the start edge was seen.
  task automatic decode_a(output logic [8:0] r, output logic stop_ok, output int t0);
    int n;
    logic [7:0] d;
    n = 0; d = '0; stop_ok = 1'b0; t0 = 0;
    while (tx_a !== 1'b0 && n < 40 * BIT_A) begin
      @(negedge clk);
      n++;
    end
    if (tx_a !== 1'b0) begin
      r = 9'h100;
      return;
    end
    t0 = cyc;
    repeat (BIT_A / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_A) @(negedge clk);
      d[i] = tx_a;
    end
    repeat (BIT_A) @(negedge clk);
    stop_ok = tx_a;
    r = {1'b0, d};
  endtask

  task automatic host_write_a(input logic [7:0] d);
    tx_data_a = d;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  initial begin
    logic [8:0] r1, r2;
    logic s1, s2;
    int t1, t2;

    vt[0] = '{7'h55, 1, 0, 1, 0, 1, 0, 7'h00};
    vt[1] = '{7'h2A, 0, 0, 0, 1, 0, 0, 7'h2A};
    vt[2] = '{7'h7F, 0, 1, 1, 0, 0, 1, 7'h00};
    vt[3] = '{7'h01, 0, 0, 0, 1, 0, 0, 7'h01};
    vt[4] = '{7'h6B, 1, 1, 1, 0, 0, 1, 7'h00};

    repeat (4) @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_txrdy", tx_ready_a, 1);
    check("rst_rxvld", rx_valid_a, 0);
    check("rst_flags", {ovr_a, ferr_a, perr_a}, 0);
    check("rst_counts", {rx_count_a, tx_count_a}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 back-to-back TX looped into RX
    loop_a = 1'b1;
    check("a_txrdy0", tx_ready_a, 1);
    host_write_a(8'hA5);
    check("a_txrdy1", tx_ready_a, 1);
    host_write_a(8'h3C);
    decode_a(r1, s1, t1);
    decode_a(r2, s2, t2);
    check("a_tx1", r1, 9'h0A5);
    check("a_tx2", r2, 9'h03C);
    check("a_stops", {s1, s2}, 2'b11);
    check("a_nogap", t2 - t1, 10 * BIT_A);
    repeat (BIT_A) @(negedge clk);
    loop_a = 1'b0;
    check("a_rxcnt", rx_count_a, 2);
    check("a_rx1", rx_data_a, 8'hA5);
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    check("a_rx2", rx_data_a, 8'h3C);
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
    check("a_rxempty", {rx_valid_a, rx_count_a}, 0);
    check("a_flags", {ovr_a, ferr_a, perr_a}, 0);

    // stop bit low on 0xFF, then clear, then idle-line glitch
    send_frame(0, 8'hFF, 8, 0, 1, BIT_A, 0, 1);
    repeat (4) @(negedge clk);
    check("a_ferr", {ovr_a, ferr_a, perr_a}, 3'b010);
    check("a_ferr_cnt", rx_count_a, 0);
    err_clr_a = 1'b1; @(negedge clk); err_clr_a = 1'b0;
    check("a_ferr_clr", ferr_a, 0);
    drv_a = 1'b0;
    repeat (4 * 16) @(negedge clk);
    drv_a = 1'b1;
    repeat (12 * BIT_A) @(negedge clk);
    check("a_glitch_flags", {ovr_a, ferr_a, perr_a}, 0);
    check("a_glitch_cnt", {rx_valid_a, rx_count_a}, 0);

    // 7E2 vector table
    for (int k = 0; k < 5; k++) begin
      send_frame(1, {1'b0, vt[k].data}, 7, 1, 2, BIT_B, vt[k].bad_par, vt[k].bad_stop);
      repeat (4) @(negedge clk);
      check($sformatf("b%0d_cnt", k), rx_count_b, vt[k].exp_cnt);
      check($sformatf("b%0d_perr", k), perr_b, vt[k].exp_perr);
      check($sformatf("b%0d_ferr", k), ferr_b, vt[k].exp_ferr);
      if (vt[k].exp_cnt != 0) begin
        check($sformatf("b%0d_data", k), rx_data_b, vt[k].exp_data);
        rx_ready_b = 1'b1; @(negedge clk); rx_ready_b = 1'b0;
      end
      if (vt[k].clr) begin
        err_clr_b = 1'b1; @(negedge clk); err_clr_b = 1'b0;
        check($sformatf("b%0d_clr", k), {perr_b, ferr_b}, 0);
      end
    end

    // depth-4 overrun
    for (int k = 1; k <= 5; k++) send_frame(2, 8'(k), 8, 0, 1, BIT_C, 0, 0);
    repeat (4) @(negedge clk);
    check("c_cnt", rx_count_c, 4);
    check("c_ovr", {ovr_c, ferr_c, perr_c}, 3'b100);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("c_pop%0d", k), {rx_valid_c, rx_data_c}, {1'b1, 8'(k)});
      rx_ready_c = 1'b1; @(negedge clk); rx_ready_c = 1'b0;
    end
    check("c_empty", {rx_valid_c, rx_count_c}, 0);

    // echo of 10 back-to-back frames
    echo_a = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++) send_frame(0, 8'(k), 8, 0, 1, BIT_A, 0, 0);
      end
      begin
        logic [8:0] r;
        logic s;
        int t;
        for (int k = 0; k < 10; k++) begin
          decode_a(r, s, t);
          echo_got[k] = r;
        end
        echo_done = 1;
      end
      begin
        while (!echo_done) begin
          @(negedge clk);
          if (rx_valid_a !== 1'b0) echo_viol++;
        end
      end
    join
    echo_a = 1'b0;
    for (int k = 0; k < 10; k++) check($sformatf("echo%0d", k), echo_got[k], 9'(k));
    check("echo_rxvld", echo_viol, 0);
    check("echo_drained", {rx_count_a, tx_count_a}, 0);

    // reset during a TX data bit
    repeat (2 * BIT_A) @(negedge clk);
    host_write_a(8'h81);
    host_write_a(8'h42);
    begin
      int n;
      n = 0;
      while (tx_a !== 1'b0 && n < 4 * BIT_A) begin @(negedge clk); n++; end
      check("rst_seen_start", tx_a, 0);
    end
    repeat (BIT_A * 2 + BIT_A / 2) @(negedge clk);
    check("rst_pre_txcnt", tx_count_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx_a, 1);
    check("rst_mid_counts", {rx_count_a, tx_count_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_txrdy", tx_ready_a, 1);
    host_write_a(8'h96);
    decode_a(r1, s1, t1);
    check("rst_new_tx", r1, 9'h096);
    check("rst_new_stop", s1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
